// File: rtl/mul_div_unit_if.sv
// Control-unit side bundle for the iterative multiply/divide unit:
// operation request, MTHI/MTLO writes, and the HI/LO/status read-back.
interface mul_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_wr;
  logic             lo_wr;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;
  logic             mult_overflow;

  modport master (
    output start, op, a, b, hi_wr, lo_wr, wr_data,
    input  busy, done, hi, lo, div_by_zero, mult_overflow
  );

  modport slave (
    input  start, op, a, b, hi_wr, lo_wr, wr_data,
    output busy, done, hi, lo, div_by_zero, mult_overflow
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative shift-add multiplier / restoring divider with architectural HI/LO.
// One bit per cycle on operand magnitudes; sign correction applied at FIN.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  mul_div_unit_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [1:0]  OP_MULT = 2'b00;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               dbz_q, dbz_d, ovf_q, ovf_d;

  // Per-bit datapath steps and final sign correction
  logic               sgn_op;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    sgn_op    = ~bus.op[0];
    a_mag     = (sgn_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_mag     = (sgn_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, mcand_q};
    // Only the low WIDTH bits matter: when div_ge holds the difference is below the divisor.
    div_diff  = div_shift[WIDTH-1:0] - mcand_q;
    prod_fix  = (neg_a_q ^ neg_b_q) ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    quo_fix   = (neg_a_q ^ neg_b_q) ? -acc_lo_q : acc_lo_q;
    rem_fix   = neg_a_q ? -acc_hi_q : acc_hi_q;
  end

  // Next-state and register updates
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.hi_wr) hi_d = bus.wr_data;
        if (bus.lo_wr) lo_d = bus.wr_data;
        if (bus.start) begin
          op_d     = bus.op;
          neg_a_d  = sgn_op & bus.a[WIDTH-1];
          neg_b_d  = sgn_op & bus.b[WIDTH-1];
          mcand_d  = b_mag;
          acc_hi_d = '0;
          acc_lo_d = a_mag;
          cnt_d    = CNT_W'(WIDTH);
          dbz_d    = 1'b0;
          ovf_d    = 1'b0;
          busy_d   = 1'b1;
          state_d  = (bus.op[1] && bus.b == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (op_q[1]) begin
          acc_hi_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
        end else begin
          acc_hi_d = mul_sum[WIDTH:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_W'(1)) state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (op_q[1]) begin
          if (mcand_q == '0) begin
            dbz_d = 1'b1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end else begin
          hi_d  = prod_fix[2*WIDTH-1:WIDTH];
          lo_d  = prod_fix[WIDTH-1:0];
          ovf_d = (op_q == OP_MULT) &&
                  (prod_fix[2*WIDTH-1:WIDTH] != {WIDTH{prod_fix[WIDTH-1]}});
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      mcand_q  <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.hi            = hi_q;
  assign bus.lo            = lo_q;
  assign bus.div_by_zero   = dbz_q;
  assign bus.mult_overflow = ovf_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit at WIDTH=32 and WIDTH=8 against an
// arithmetic reference model of HI/LO and the status flags.
module tb_mul_div_unit;
  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  logic [63:0] hi_m, lo_m;     // expected HI/LO of the 32-bit unit
  logic [63:0] hi8_m, lo8_m;   // expected HI/LO of the 8-bit unit

  mul_div_unit_if #(.WIDTH(32)) bus32();
  mul_div_unit_if #(.WIDTH(8))  bus8();

  mul_div_unit #(.WIDTH(32)) u_dut32 (.clk(clk), .reset(reset), .bus(bus32));
  mul_div_unit #(.WIDTH(8))  u_dut8  (.clk(clk), .reset(reset), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain signed/unsigned arithmetic on w-bit operands
  function automatic void ref_model(input int unsigned w, input logic [1:0] op,
                                    input logic [63:0] a, input logic [63:0] b,
                                    input logic [63:0] hi_in, input logic [63:0] lo_in,
                                    output logic [63:0] hi_o, output logic [63:0] lo_o,
                                    output logic dbz, output logic ovf);
    logic [63:0] mask;
    logic [63:0] full;
    longint      sa, sb, p, q, r, lim;
    mask = (64'd1 << w) - 64'd1;
    sa   = longint'(a);
    sb   = longint'(b);
    if (!op[0] && a[w-1]) sa = sa - longint'(64'd1 << w);
    if (!op[0] && b[w-1]) sb = sb - longint'(64'd1 << w);
    dbz = 1'b0;
    ovf = 1'b0;
    if (!op[1]) begin
      p    = sa * sb;
      full = op[0] ? a * b : 64'(p);
      hi_o = (full >> w) & mask;
      lo_o = full & mask;
      lim  = longint'(64'd1 << (w - 1));
      ovf  = (op == 2'b00) && (p > lim - 1 || p < -lim);
    end else if (sb == 0) begin
      hi_o = hi_in;
      lo_o = lo_in;
      dbz  = 1'b1;
    end else begin
      q    = sa / sb;
      r    = sa % sb;
      lo_o = 64'(q) & mask;
      hi_o = 64'(r) & mask;
    end
  endfunction

  function automatic logic [31:0] pick32();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h0;
      1: v = 32'h1;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'h8000_0000;
      4: v = 32'h7FFF_FFFF;
      5: v = 32'($urandom_range(0, 300));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic mt32(input logic hw, input logic lw, input logic [31:0] data);
    bus32.hi_wr = hw; bus32.lo_wr = lw; bus32.wr_data = data;
    @(posedge clk); #1;
    bus32.hi_wr = 1'b0; bus32.lo_wr = 1'b0;
    if (hw) hi_m = 64'(data);
    if (lw) lo_m = 64'(data);
  endtask

  // Issue one op on the 32-bit unit and check latency, busy, HI/LO and flags
  task automatic run_op32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string name);
    logic [63:0] eh, el;
    logic        edbz, eovf;
    int          n, exp_lat;
    ref_model(32, op, 64'(a), 64'(b), hi_m, lo_m, eh, el, edbz, eovf);
    exp_lat = edbz ? 2 : 34;
    bus32.op = op; bus32.a = a; bus32.b = b; bus32.start = 1'b1;
    @(posedge clk); #1;
    bus32.start = 1'b0; bus32.a = $urandom; bus32.b = $urandom;
    n = 1;
    vectors++;
    if (bus32.busy !== 1'b1 || bus32.div_by_zero !== 1'b0 || bus32.mult_overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL %s cycle1: busy/dbz/ovf got %b%b%b want 100", name,
               bus32.busy, bus32.div_by_zero, bus32.mult_overflow);
    end
    while (bus32.done !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    vectors++;
    if (n !== exp_lat) begin
      miscompares++;
      $display("FAIL %s latency: got %0d want %0d", name, n, exp_lat);
    end
    vectors++;
    if (bus32.hi !== eh[31:0] || bus32.lo !== el[31:0]) begin
      miscompares++;
      $display("FAIL %s hi/lo: got %h/%h want %h/%h", name, bus32.hi, bus32.lo, eh[31:0], el[31:0]);
    end
    vectors++;
    if (bus32.div_by_zero !== edbz || bus32.mult_overflow !== eovf || bus32.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s flags: dbz/ovf/busy got %b%b%b want %b%b0", name,
               bus32.div_by_zero, bus32.mult_overflow, bus32.busy, edbz, eovf);
    end
    hi_m = eh; lo_m = el;
  endtask

  task automatic run_op8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         input string name);
    logic [63:0] eh, el;
    logic        edbz, eovf;
    int          n, exp_lat;
    ref_model(8, op, 64'(a), 64'(b), hi8_m, lo8_m, eh, el, edbz, eovf);
    exp_lat = edbz ? 2 : 10;
    bus8.op = op; bus8.a = a; bus8.b = b; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    n = 1;
    while (bus8.done !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    vectors++;
    if (n !== exp_lat) begin
      miscompares++;
      $display("FAIL %s latency: got %0d want %0d", name, n, exp_lat);
    end
    vectors++;
    if (bus8.hi !== eh[7:0] || bus8.lo !== el[7:0] ||
        bus8.div_by_zero !== edbz || bus8.mult_overflow !== eovf) begin
      miscompares++;
      $display("FAIL %s: hi/lo/dbz/ovf got %h/%h/%b/%b want %h/%h/%b/%b", name,
               bus8.hi, bus8.lo, bus8.div_by_zero, bus8.mult_overflow,
               eh[7:0], el[7:0], edbz, eovf);
    end
    hi8_m = eh; lo8_m = el;
  endtask

  task automatic test_reset();
    tick(3);
    vectors++;
    if (bus32.hi !== 32'h0 || bus32.lo !== 32'h0 || bus32.busy !== 1'b0 || bus32.done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_held: hi/lo/busy/done got %h/%h/%b/%b want 0", bus32.hi, bus32.lo,
               bus32.busy, bus32.done);
    end
    reset = 1'b1;
    tick(2);
    vectors++;
    if (bus32.hi !== 32'h0 || bus32.lo !== 32'h0 || bus32.busy !== 1'b0 || bus32.done !== 1'b0 ||
        bus8.hi !== 8'h0 || bus8.lo !== 8'h0) begin
      miscompares++;
      $display("FAIL reset_release: hi/lo/busy/done got %h/%h/%b/%b want 0", bus32.hi, bus32.lo,
               bus32.busy, bus32.done);
    end
    hi_m = '0; lo_m = '0; hi8_m = '0; lo8_m = '0;
  endtask

  task automatic test_directed();
    run_op32(2'b00, 32'hFFFF_FFFD, 32'd7, "mult_neg3x7");
    vectors++;
    if (bus32.hi !== 32'hFFFF_FFFF || bus32.lo !== 32'hFFFF_FFEB) begin
      miscompares++;
      $display("FAIL mult_neg3x7_const: got %h/%h want ffffffff/ffffffeb", bus32.hi, bus32.lo);
    end
    run_op32(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run_op32(2'b00, 32'h0001_0000, 32'h0001_0000, "mult_ovf");
    vectors++;
    if (bus32.mult_overflow !== 1'b1 || bus32.hi !== 32'h1) begin
      miscompares++;
      $display("FAIL mult_ovf_const: ovf/hi got %b/%h want 1/00000001", bus32.mult_overflow, bus32.hi);
    end
    run_op32(2'b10, 32'hFFFF_FFF9, 32'd2, "div_neg7_2");
    run_op32(2'b11, 32'd100, 32'd7, "divu_100_7");
    run_op32(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
    vectors++;
    if (bus32.lo !== 32'h8000_0000 || bus32.hi !== 32'h0) begin
      miscompares++;
      $display("FAIL div_min_m1_const: got %h/%h want 00000000/80000000", bus32.hi, bus32.lo);
    end
  endtask

  task automatic test_div_zero();
    mt32(1'b1, 1'b0, 32'h11);
    mt32(1'b0, 1'b1, 32'h22);
    run_op32(2'b10, 32'd5, 32'd0, "div_by_zero");
    tick(3);
    vectors++;
    if (bus32.div_by_zero !== 1'b1 || bus32.hi !== 32'h11 || bus32.lo !== 32'h22) begin
      miscompares++;
      $display("FAIL dbz_sticky: dbz/hi/lo got %b/%h/%h want 1/11/22", bus32.div_by_zero,
               bus32.hi, bus32.lo);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_op32(2'($urandom), pick32(), pick32(), "random32");
    end
  endtask

  task automatic test_back_to_back();
    run_op32(2'b11, 32'd9, 32'd0, "b2b_dbz");
    run_op32(2'b01, 32'd12, 32'd12, "b2b_multu");
    run_op32(2'b10, 32'hFFFF_FF00, 32'd3, "b2b_div");
  endtask

  task automatic test_collision();
    int n, dones, done_at;
    bus32.op = 2'b11; bus32.a = 32'd100; bus32.b = 32'd7; bus32.start = 1'b1;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    dones = 0; done_at = 0;
    for (n = 2; n <= 60; n++) begin
      if (n == 5) begin
        bus32.op = 2'b01; bus32.a = 32'd3; bus32.b = 32'd5; bus32.start = 1'b1;
        bus32.lo_wr = 1'b1; bus32.wr_data = 32'hDEAD;
      end
      if (n == 7) begin
        bus32.start = 1'b0; bus32.lo_wr = 1'b0;
      end
      @(posedge clk); #1;
      if (bus32.done === 1'b1) begin
        dones++;
        if (done_at == 0) done_at = n;
      end
    end
    vectors++;
    if (dones !== 1 || done_at !== 34) begin
      miscompares++;
      $display("FAIL busy_start: done pulses/cycle got %0d/%0d want 1/34", dones, done_at);
    end
    vectors++;
    if (bus32.hi !== 32'd2 || bus32.lo !== 32'd14 || bus32.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL run_writes_ignored: hi/lo/busy got %h/%h/%b want 2/e/0", bus32.hi,
               bus32.lo, bus32.busy);
    end
    hi_m = 64'd2; lo_m = 64'd14;

    bus32.op = 2'b01; bus32.a = 32'd6; bus32.b = 32'd7; bus32.start = 1'b1;
    bus32.hi_wr = 1'b1; bus32.wr_data = 32'hABCD;
    @(posedge clk); #1;
    bus32.start = 1'b0; bus32.hi_wr = 1'b0;
    vectors++;
    if (bus32.hi !== 32'hABCD) begin
      miscompares++;
      $display("FAIL hi_wr_with_start_early: hi got %h want 0000abcd", bus32.hi);
    end
    n = 1;
    while (bus32.done !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    vectors++;
    if (n !== 34 || bus32.hi !== 32'h0 || bus32.lo !== 32'd42) begin
      miscompares++;
      $display("FAIL hi_wr_with_start_final: cycle/hi/lo got %0d/%h/%h want 34/0/2a", n,
               bus32.hi, bus32.lo);
    end
    hi_m = 64'd0; lo_m = 64'd42;
  endtask

  task automatic test_reset_mid_run();
    int activity;
    mt32(1'b1, 1'b1, 32'h5A5A_5A5A);
    bus32.op = 2'b00; bus32.a = $urandom; bus32.b = $urandom; bus32.start = 1'b1;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    tick(10);
    reset = 1'b0;
    #1;
    vectors++;
    if (bus32.hi !== 32'h0 || bus32.lo !== 32'h0 || bus32.busy !== 1'b0 || bus32.done !== 1'b0 ||
        bus32.div_by_zero !== 1'b0 || bus32.mult_overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_run: hi/lo/busy/done got %h/%h/%b/%b want 0", bus32.hi,
               bus32.lo, bus32.busy, bus32.done);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    activity = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus32.busy !== 1'b0 || bus32.done !== 1'b0 || bus32.hi !== 32'h0) activity++;
    end
    vectors++;
    if (activity !== 0) begin
      miscompares++;
      $display("FAIL reset_abort: cycles with activity got %0d want 0", activity);
    end
    hi_m = '0; lo_m = '0; hi8_m = '0; lo8_m = '0;
    run_op32(2'b10, 32'd1000, 32'hFFFF_FFF6, "after_reset");
  endtask

  task automatic test_width8();
    run_op8(2'b01, 8'hFF, 8'hFF, "w8_multu_ff");
    vectors++;
    if (bus8.hi !== 8'hFE || bus8.lo !== 8'h01) begin
      miscompares++;
      $display("FAIL w8_multu_const: got %h/%h want fe/01", bus8.hi, bus8.lo);
    end
    run_op8(2'b10, 8'h80, 8'hFF, "w8_div_min_m1");
    for (int i = 0; i < 20; i++) begin
      run_op8(2'($urandom), 8'($urandom), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom), "random8");
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b0;
    bus32.start = 1'b0; bus32.op = '0; bus32.a = '0; bus32.b = '0;
    bus32.hi_wr = 1'b0; bus32.lo_wr = 1'b0; bus32.wr_data = '0;
    bus8.start = 1'b0; bus8.op = '0; bus8.a = '0; bus8.b = '0;
    bus8.hi_wr = 1'b0; bus8.lo_wr = 1'b0; bus8.wr_data = '0;
    test_reset();
    test_directed();
    test_div_zero();
    test_back_to_back();
    test_collision();
    test_random();
    test_reset_mid_run();
    test_width8();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
